bin_to_bcd_scan: RTL and testbench
==================================

BIN_TO_BCD_SCAN -- requirements
Module: bin_to_bcd_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 14, binary input width (covers 0..9999).
REQ-002 SHALL have parameter MAXVAL, default 9999, largest displayable value; larger inputs clamp to it.
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-004 SHALL have port Reset_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have port bin  input  WIDTH  binary value to convert, e.g. counter output zero-extended.
REQ-006 SHALL have port start  input  1  conversion request, sampled on the rising clk edge.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a new result on bcd/blank/ovf.
REQ-009 SHALL have port bcd  output  16  four packed BCD digits, [15:12] thousands .. [3:0] units.
REQ-010 SHALL have port blank  output  4  leading-zero blank mask, one bit per digit, same order as bcd.
REQ-011 SHALL have port ovf  output  1  high when the last accepted input exceeded MAXVAL.

Function
REQ-012 SHALL implement an FSM with two states: IDLE and SHIFT.
REQ-013 ready SHALL be high exactly when the state is IDLE.
REQ-014 In IDLE, start=1 at an edge SHALL accept bin.
- On acceptance: load min(bin, MAXVAL) into the shift register; clear the BCD accumulator; clear the iteration counter; latch ovf_pending = (bin > MAXVAL); go to SHIFT.
REQ-015 start while in SHIFT SHALL be ignored: no queuing and no effect on the conversion in progress.
REQ-016 Each SHIFT edge SHALL perform one double-dabble step.
- First, add 3 to every accumulator digit that is >= 5.
- Then shift {accumulator, shift register} left by one bit.
- Increment the iteration counter.
REQ-017 On the edge completing step WIDTH (the 14th by default), the FSM SHALL do all of the following at once:
- load the final accumulator into bcd;
- load ovf_pending into ovf;
- update blank;
- assert done for one cycle;
- return to IDLE.
REQ-018 Latency: accept at edge k -> done high and the new bcd/blank/ovf valid in the cycle after edge k+WIDTH.
- ready is high in that same cycle.
- The earliest next accept is edge k+WIDTH+1.
REQ-019 bcd, blank and ovf SHALL change only on the completion edge and SHALL otherwise hold the last result.
REQ-020 blank[3] SHALL be set iff digit 3 is 0.
REQ-021 blank[2] SHALL be set iff digits 3 and 2 are both 0.
REQ-022 blank[1] SHALL be set iff digits 3, 2 and 1 are all 0.
REQ-023 blank[0] SHALL always be 0, so the units digit is always shown.
REQ-024 Every digit of bcd SHALL be in 0..9 at all times.
REQ-025 No intermediate accumulator value SHALL ever appear on bcd.
REQ-026 done SHALL never be asserted in two consecutive cycles.
REQ-027 Iteration counter width SHALL be ceil(log2(WIDTH+1)); the counter SHALL not wrap within a conversion.

Reset
REQ-028 Reset_N low SHALL immediately put the block in this state, regardless of clk:
- state=IDLE, ready=1, done=0;
- bcd=16'h0000, blank=4'b1110, ovf=0;
- accumulator, shift register, counter and ovf_pending cleared.
REQ-029 Reset asserted mid-conversion SHALL abort it with no done pulse; the partial result is discarded.
REQ-030 After Reset_N deasserts, the first start SHALL be accepted on the first clk edge at which it is high.

Verification
REQ-031 bin=1234, start pulsed one cycle -> after 14 cycles: done=1 for one cycle, bcd=16'h1234, blank=4'b0000, ovf=0.
REQ-032 Leading-zero inputs:
- bin=7 -> bcd=16'h0007, blank=4'b1110.
- bin=0 -> bcd=16'h0000, blank=4'b1110.
- bin=40 -> bcd=16'h0040, blank=4'b1100.
REQ-033 Overflow inputs:
- bin=12000 -> bcd=16'h9999, ovf=1, blank=4'b0000.
- The next conversion with bin=255 -> bcd=16'h0255, ovf=0, blank=4'b1000.
REQ-034 bin=5678 accepted, then start=1 with bin=1111 held for cycles 1..13 -> exactly one done, bcd=16'h5678; ready stays low until the done cycle.
REQ-035 Reset mid-conversion:
- Accept bin=9999, assert Reset_N low at step 6 -> bcd=0, blank=4'b1110, ready=1, no done pulse.
- After release, bin=42 -> bcd=16'h0042.
REQ-036 Back-to-back: start held high continuously with bin cycling 0..9999 -> every done result matches the decimal of the value accepted; consecutive done pulses are exactly 15 cycles apart.

Source files
------------

// File: rtl/bin_to_bcd_scan.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_scan
// Description : Sequential double-dabble binary-to-BCD converter, one bit per
//               clock, with input clamping and a leading-zero blank mask.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_scan #(
    parameter int WIDTH  = 14,
    parameter int MAXVAL = 9999
) (
    input  logic             clk,
    input  logic             Reset_N,
    input  logic [WIDTH-1:0] bin,
    input  logic             start,
    output logic             ready,
    output logic             done,
    output logic [15:0]      bcd,
    output logic [3:0]       blank,
    output logic             ovf
);

    localparam int                 c_CNT_W  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   c_MAXVAL = WIDTH'(MAXVAL);
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_sr;
    logic [15:0]        r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ovf_pend;
    logic [15:0]        r_bcd;
    logic [3:0]         r_blank;
    logic               r_ovf;
    logic               r_done;

    logic [WIDTH-1:0]   w_clamped;
    logic               w_over;
    logic [15:0]        w_adj;
    logic [15:0]        w_acc_shift;
    logic [WIDTH-1:0]   w_sr_shift;
    logic [3:0]         w_blank;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                if (r_cnt == c_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = c_S_IDLE;
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    assign ready = (r_state == c_S_IDLE);

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    assign w_over    = (bin > c_MAXVAL);
    assign w_clamped = w_over ? c_MAXVAL : bin;

    for (genvar g = 0; g < 4; g++) begin : g_digit
        assign w_adj[4*g +: 4] = (r_acc[4*g +: 4] >= 4'd5) ? (r_acc[4*g +: 4] + 4'd3)
                                                            : r_acc[4*g +: 4];
    end

    // The clamp keeps the value below 10000, so the bit leaving the top is 0.
    assign w_acc_shift = 16'({w_adj, r_sr[WIDTH-1]});
    assign w_sr_shift  = {r_sr[WIDTH-2:0], 1'b0};

    assign w_blank[3] = (w_acc_shift[15:12] == 4'd0);
    assign w_blank[2] = w_blank[3] && (w_acc_shift[11:8] == 4'd0);
    assign w_blank[1] = w_blank[2] && (w_acc_shift[7:4] == 4'd0);
    assign w_blank[0] = 1'b0;

    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_sr       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_bcd      <= 16'h0000;
            r_blank    <= 4'b1110;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_sr       <= w_clamped;
                r_acc      <= '0;
                r_cnt      <= '0;
                r_ovf_pend <= w_over;
            end else if (r_state == c_S_SHIFT) begin
                r_acc <= w_acc_shift;
                r_sr  <= w_sr_shift;
                r_cnt <= r_cnt + c_ONE;
            end
            // Visible outputs move only on the completion edge.
            if (w_last) begin
                r_bcd   <= w_acc_shift;
                r_blank <= w_blank;
                r_ovf   <= r_ovf_pend;
            end
        end
    end

    assign done  = r_done;
    assign bcd   = r_bcd;
    assign blank = r_blank;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_scan
// Description : Self-checking bench for bin_to_bcd_scan (vectors, corner
//               sequences, random conversions against a decimal model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_scan;

    localparam int c_WIDTH = 14;
    localparam int c_LAT   = c_WIDTH + 1;

    logic        clk;
    logic        Reset_N;
    logic [13:0] bin;
    logic        start;
    logic        ready;
    logic        done;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;

    int n_checks;
    int n_errors;

    bin_to_bcd_scan #(.WIDTH(c_WIDTH), .MAXVAL(9999)) dut (
        .clk    (clk),
        .Reset_N(Reset_N),
        .bin    (bin),
        .start  (start),
        .ready  (ready),
        .done   (done),
        .bcd    (bcd),
        .blank  (blank),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int          val;
        logic [15:0] e_bcd;
        logic [3:0]  e_blank;
        logic        e_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: clamp, then decimal digits by plain arithmetic.
    task automatic model(input int v, output logic [15:0] m_bcd, output logic [3:0] m_blank,
                         output logic m_ovf);
        int c;
        int d[4];
        c     = (v > 9999) ? 9999 : v;
        m_ovf = (v > 9999);
        d[3]  = c / 1000;
        d[2]  = (c / 100) % 10;
        d[1]  = (c / 10) % 10;
        d[0]  = c % 10;
        m_bcd = {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0]};
        m_blank[3] = (c < 1000);
        m_blank[2] = (c < 100);
        m_blank[1] = (c < 10);
        m_blank[0] = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    // One conversion; returns number of cycles from accept until done is seen.
    task automatic convert(input int v, output int lat, output logic held_ok);
        logic [15:0] prev;
        wait_ready();
        prev    = bcd;
        held_ok = 1'b1;
        bin     = 14'(v);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            if (bcd !== prev || ready) held_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic convert_check(input string name, input int v, input logic [15:0] e_bcd,
                                 input logic [3:0] e_blank, input logic e_ovf);
        int   lat;
        logic held;
        convert(v, lat, held);
        chk({name, "_latency"}, 32'(lat), 32'(c_LAT));
        chk({name, "_bcd"}, 32'(bcd), 32'(e_bcd));
        chk({name, "_blank"}, 32'(blank), 32'(e_blank));
        chk({name, "_ovf"}, 32'(ovf), 32'(e_ovf));
        chk({name, "_ready_at_done"}, 32'(ready), 32'd1);
        chk({name, "_hold"}, 32'(held), 32'd1);
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [15:0] m_bcd;
        logic [3:0]  m_blank;
        logic        m_ovf;
        int          lat;
        int          n_done;
        logic        ok;
        int          q_acc[$];
        int          bval;
        int          last_done;
        int          cyc;

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{1234,  16'h1234, 4'b0000, 1'b0};
        vecs[1] = '{7,     16'h0007, 4'b1110, 1'b0};
        vecs[2] = '{0,     16'h0000, 4'b1110, 1'b0};
        vecs[3] = '{40,    16'h0040, 4'b1100, 1'b0};
        vecs[4] = '{12000, 16'h9999, 4'b0000, 1'b1};
        vecs[5] = '{255,   16'h0255, 4'b1000, 1'b0};
        vecs[6] = '{9999,  16'h9999, 4'b0000, 1'b0};
        vecs[7] = '{16383, 16'h9999, 4'b0000, 1'b1};

        Reset_N = 1'b0;
        start   = 1'b0;
        bin     = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_blank", 32'(blank), 32'(4'b1110));
        chk("reset_ovf", 32'(ovf), 32'd0);
        Reset_N = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            convert_check($sformatf("vec%0d", i), vecs[i].val, vecs[i].e_bcd, vecs[i].e_blank,
                          vecs[i].e_ovf);

        // start held during a conversion must be ignored.
        wait_ready();
        bin   = 14'd5678;
        start = 1'b1;
        @(negedge clk);
        bin    = 14'd1111;
        n_done = 0;
        ok     = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            if (ready || done) ok = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        for (int c = 14; c <= 20; c++) begin
            if (done) begin
                n_done++;
                chk("hold_start_lat", 32'(c), 32'(c_LAT));
                chk("hold_start_bcd", 32'(bcd), 32'h5678);
            end
            if (c < c_LAT && ready) ok = 1'b0;
            @(negedge clk);
        end
        chk("hold_start_ready_low", 32'(ok), 32'd1);
        chk("hold_start_one_done", 32'(n_done), 32'd1);

        // Asynchronous reset in the middle of a conversion.
        wait_ready();
        bin   = 14'd9999;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #3 Reset_N = 1'b0;
        #1;
        chk("midrst_bcd", 32'(bcd), 32'h0);
        chk("midrst_blank", 32'(blank), 32'(4'b1110));
        chk("midrst_ready", 32'(ready), 32'd1);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) ok = 1'b0;
        end
        Reset_N = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) ok = 1'b0;
        end
        chk("midrst_no_done", 32'(ok), 32'd1);
        convert_check("after_rst", 42, 16'h0042, 4'b1100, 1'b0);

        // Random conversions against the decimal model.
        for (int i = 0; i < 40; i++) begin
            bval = int'($urandom_range(0, 16383));
            if (i % 4 == 0) bval = int'($urandom_range(0, 99));
            model(bval, m_bcd, m_blank, m_ovf);
            convert_check($sformatf("rnd%0d_%0d", i, bval), bval, m_bcd, m_blank, m_ovf);
        end

        // Back-to-back with start held high and bin changing every cycle.
        wait_ready();
        bval      = 9990;
        start     = 1'b1;
        last_done = -1;
        n_done    = 0;
        cyc       = 0;
        while (n_done < 8 && cyc < 400) begin
            bin = 14'(bval);
            if (done) begin
                n_done++;
                if (q_acc.size() == 0) begin
                    chk("b2b_spurious_done", 32'd1, 32'd0);
                end else begin
                    model(q_acc.pop_front(), m_bcd, m_blank, m_ovf);
                    chk("b2b_bcd", 32'(bcd), 32'(m_bcd));
                    chk("b2b_blank", 32'(blank), 32'(m_blank));
                end
                if (last_done >= 0) chk("b2b_spacing", 32'(cyc - last_done), 32'(c_LAT));
                last_done = cyc;
            end
            if (ready) q_acc.push_back(bval);
            @(negedge clk);
            cyc++;
            bval = (bval + 1237) % 10000;
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(n_done), 32'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
